fetch_queue: RTL and testbench

- Instruction-fetch front end that sits directly upstream of the decoder.
- Owns the fetch PC and issues in-order read requests to the instruction memory.
- Buffers returned instructions together with their PCs in a FIFO and presents them to decode over a valid/ready handshake.
- Handles redirects (taken branch/jump) by flushing buffered and in-flight fetches.

---
 rtl/fetch_queue.sv | 121 ++++++++++++
 tb/tb_fetch_queue.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, issues credit-limited imem reads and
// buffers {pc, instr} for decode. Define FETCH_QUEUE_BYPASS_EN for zero-latency empty-queue bypass.
module fetch_queue #(
  parameter int          DEPTH           = 4,
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int OW = $clog2(MAX_OUTSTANDING) + 1;
  localparam int RW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  logic [31:0]   fetch_pc;
  logic [31:0]   pc_mem    [DEPTH];
  logic [31:0]   instr_mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] fifo_count;

  logic [31:0]   req_pc_mem [MAX_OUTSTANDING];
  logic [RW-1:0] req_rd, req_wr;
  logic [OW-1:0] outstanding, drop_cnt;

  logic [31:0] in_use;
  logic        req_fire, rsp_keep, fifo_empty, bypass, push, pop;
  logic [RW-1:0] req_rd_next, req_wr_next;

  always_comb begin
    in_use      = 32'(fifo_count) + 32'(outstanding);
    fifo_empty  = (fifo_count == '0);
    // Outstanding counts stale (to-be-dropped) requests too, so credit stays conservative.
    imem_req_valid = rst && !redirect_valid && (in_use < 32'(DEPTH))
                     && (32'(outstanding) < 32'(MAX_OUTSTANDING));
    imem_req_addr  = fetch_pc;
    req_fire       = imem_req_valid && imem_req_ready;
    rsp_keep       = imem_rsp_valid && (drop_cnt == '0) && !redirect_valid;
`ifdef FETCH_QUEUE_BYPASS_EN
    bypass = rsp_keep && fifo_empty && out_ready;
`else
    bypass = 1'b0;
`endif
    push = rsp_keep && !bypass;
    pop  = !fifo_empty && out_ready;

    req_rd_next = (req_rd == RW'(MAX_OUTSTANDING - 1)) ? '0 : req_rd + RW'(1);
    req_wr_next = (req_wr == RW'(MAX_OUTSTANDING - 1)) ? '0 : req_wr + RW'(1);

    out_valid = !fifo_empty || bypass;
    out_pc    = 32'h0;
    out_instr = 32'h0;
    if (bypass) begin
      out_pc    = req_pc_mem[req_rd];
      out_instr = imem_rsp_data;
    end else if (!fifo_empty) begin
      out_pc    = pc_mem[rd_ptr];
      out_instr = instr_mem[rd_ptr];
    end
  end

  always_ff @(posedge clk) begin
    if (rst && push) begin
      pc_mem[wr_ptr]    <= req_pc_mem[req_rd];
      instr_mem[wr_ptr] <= imem_rsp_data;
    end
    if (rst && req_fire) req_pc_mem[req_wr] <= fetch_pc;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_pc    <= RESET_PC;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      fifo_count  <= '0;
      req_rd      <= '0;
      req_wr      <= '0;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      if (redirect_valid) begin
        fetch_pc   <= redirect_pc & 32'hFFFF_FFFC;
        rd_ptr     <= '0;
        wr_ptr     <= '0;
        fifo_count <= '0;
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + 32'd4;
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        case ({push, pop})
          2'b10:   fifo_count <= fifo_count + CW'(1);
          2'b01:   fifo_count <= fifo_count - CW'(1);
          default: fifo_count <= fifo_count;
        endcase
      end

      if (req_fire)       req_wr <= req_wr_next;
      if (imem_rsp_valid) req_rd <= req_rd_next;
      outstanding <= outstanding + OW'(req_fire) - OW'(imem_rsp_valid);

      // Everything still in flight after this cycle's response belongs to the old stream.
      if (redirect_valid)
        drop_cnt <= outstanding - OW'(imem_rsp_valid);
      else if (imem_rsp_valid && (drop_cnt != '0))
        drop_cnt <= drop_cnt - OW'(1);
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: directed scenarios push expected {pc, instr} pairs,
// a monitor pops and compares on every out handshake; a queue-based memory model serves imem.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;

  always #5 clk = ~clk;

  fetch_queue dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc)
  );

`ifdef FETCH_QUEUE_BYPASS_EN
  localparam int LAT_EXP = 0;
`else
  localparam int LAT_EXP = 1;
`endif

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;
  exp_t exp_q[$];
  exp_t me;

  task automatic expect_pc(input logic [31:0] pc);
    exp_t e;
    e.pc    = pc;
    e.instr = mem_word(pc);
    exp_q.push_back(e);
  endtask

  // Memory model: in-order, fixed latency, optional hold; cleared by reset.
  typedef struct { logic [31:0] addr; int due; } pend_t;
  pend_t pend_q[$];
  pend_t mp;
  int    mem_lat      = 1;
  bit    mem_hold     = 1'b0;
  int    req_cnt      = 0;
  int    first_rsp_cyc = -1;

  initial begin
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        pend_q.delete();
        req_cnt = 0;
      end else if (imem_req_valid && imem_req_ready) begin
        mp.addr = imem_req_addr;
        mp.due  = cyc + mem_lat;
        pend_q.push_back(mp);
        req_cnt++;
      end
      @(posedge clk);
      #1;
      if (!mem_hold && pend_q.size() > 0 && pend_q[0].due <= cyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(pend_q[0].addr);
        if (first_rsp_cyc < 0) first_rsp_cyc = cyc;
        void'(pend_q.pop_front());
      end else begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
      end
    end
  end

  // Monitor: every handshake must match the next expected entry; extras are failures.
  int pop_cyc[$];
  int first_valid_cyc = -1;
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_out: got pc %h instr %h, expected no output", out_pc, out_instr);
          end else begin
            me = exp_q.pop_front();
            check("out_pc", out_pc, me.pc);
            check("out_instr", out_instr, me.instr);
            pop_cyc.push_back(cyc);
          end
        end
      end
    end
  end

  task automatic drain(input string name, input int budget);
    int n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_drain: %0d entries never appeared, expected 0 left", name, exp_q.size());
      exp_q.delete();
    end
    #1;
    out_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst            = 1'b0;
    redirect_valid = 1'b0;
    out_ready      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    rst            = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    out_ready      = 1'b0;
    imem_req_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_req_addr", imem_req_addr, 32'h0);
    check("rst_out_pc", out_pc, 32'h0);
    check("rst_out_instr", out_instr, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Streaming, 1-cycle memory, decode always ready
    mem_lat = 1;
    pop_cyc.delete();
    for (int i = 0; i < 8; i++) expect_pc(32'(i * 4));
    out_ready = 1'b1;
    drain("stream", 60);
    checks++;
    if (pop_cyc.size() != 8 || pop_cyc[7] - pop_cyc[0] != 7) begin
      failures++;
      $display("FAIL stream_rate: got %0d pops spanning %0d cycles, expected 8 spanning 7",
               pop_cyc.size(), (pop_cyc.size() > 0) ? pop_cyc[pop_cyc.size()-1] - pop_cyc[0] : -1);
    end

    // Backpressure: credit caps total requests at DEPTH
    do_reset();
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("bp_req_cnt", 32'(req_cnt), 32'd4);
    check("bp_out_valid", 32'(out_valid), 32'd1);
    check("bp_out_pc", out_pc, 32'h0);
    check("bp_out_instr", out_instr, mem_word(32'h0));
    @(posedge clk);
    #1;
    for (int i = 0; i < 6; i++) expect_pc(32'(i * 4));
    out_ready = 1'b1;
    drain("bp", 60);

    // Redirect with two requests in flight: both responses must be dropped
    do_reset();
    mem_hold = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("rd_inflight_reqs", 32'(req_cnt), 32'd2);
    check("rd_credit_stall", 32'(imem_req_valid), 32'd0);
    @(posedge clk);
    #1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0103;
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    mem_hold       = 1'b0;
    @(negedge clk);
    check("rd_req_addr", imem_req_addr, 32'h0000_0100);
    check("rd_out_valid", 32'(out_valid), 32'd0);
    expect_pc(32'h100);
    expect_pc(32'h104);
    expect_pc(32'h108);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    drain("redirect", 60);

    // Redirect in the same cycle as the handshake on pc 0x4
    do_reset();
    mem_lat = 1;
    repeat (8) @(posedge clk);
    #1;
    expect_pc(32'h0);
    expect_pc(32'h4);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h2000_0041;
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    @(negedge clk);
    check("rdhs_consumed", 32'(exp_q.size()), 32'd0);
    check("rdhs_out_valid", 32'(out_valid), 32'd0);
    check("rdhs_req_addr", imem_req_addr, 32'h2000_0040);
    expect_pc(32'h2000_0040);
    expect_pc(32'h2000_0044);
    expect_pc(32'h2000_0048);
    drain("rdhs", 60);

    // Reset mid-stream with the queue partly full and a response in flight
    do_reset();
    mem_lat = 2;
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("mrst_out_valid", 32'(out_valid), 32'd0);
    check("mrst_req_addr", imem_req_addr, 32'h0);
    check("mrst_req_valid", 32'(imem_req_valid), 32'd0);
    @(posedge clk);
    #1;
    rst     = 1'b1;
    mem_lat = 1;
    for (int i = 0; i < 4; i++) expect_pc(32'(i * 4));
    out_ready = 1'b1;
    drain("mrst", 60);

    // PC wrap at the top of the address space
    do_reset();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFF8;
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    expect_pc(32'hFFFF_FFF8);
    expect_pc(32'hFFFF_FFFC);
    expect_pc(32'h0000_0000);
    expect_pc(32'h0000_0004);
    out_ready = 1'b1;
    drain("wrap", 60);

    // Response-to-out_valid latency on an empty queue
    do_reset();
    mem_lat         = 1;
    first_rsp_cyc   = -1;
    first_valid_cyc = -1;
    expect_pc(32'h0);
    expect_pc(32'h4);
    out_ready = 1'b1;
    drain("lat", 60);
    check("lat_cycles", 32'(first_valid_cyc - first_rsp_cyc), 32'(LAT_EXP));

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
